// File: rtl/kd_tree_config_ctrl.sv
// Configuration sequencer for the KD-tree node array: streams node words into sequential addresses.
// Optional build macro KD_CFG_IDX_CHECK_EN enables the sticky split-index range check on err.
module kd_tree_config_ctrl #(
  parameter int STORAGE_WIDTH = 22,
  parameter int NUM_NODES     = 31,
  parameter int ADDR_WIDTH    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [STORAGE_WIDTH-1:0] in_data,
  output logic                     in_ready,
  output logic                     node_wen,
  output logic [ADDR_WIDTH-1:0]    node_addr,
  output logic [STORAGE_WIDTH-1:0] node_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  accept, last, restart;

  assign accept  = in_valid && in_ready;
  assign last    = (cnt == ADDR_WIDTH'(NUM_NODES - 1));
  assign restart = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (accept && last) state_nxt = DONE;
      DONE:    if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Flags decode the registered state only, so in_ready falls on the last accept edge.
  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      node_wen   <= 1'b0;
      node_addr  <= '0;
      node_wdata <= '0;
    end else begin
      node_wen <= accept;
      if (restart)              cnt <= '0;
      else if (accept && !last) cnt <= cnt + 1'b1;
      if (accept) begin
        node_addr  <= cnt;
        node_wdata <= in_data;
      end
    end
  end

`ifdef KD_CFG_IDX_CHECK_EN
  // Split index must address one of the 5 feature dimensions; word is still written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  err <= 1'b0;
    else if (restart)                         err <= 1'b0;
    else if (accept && (in_data[2:0] > 3'd4)) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_kd_tree_config_ctrl.sv
// Randomized bench for kd_tree_config_ctrl: cycle model of pass phases plus a write scoreboard.
module tb_kd_tree_config_ctrl;
  localparam int SW = 22;
  localparam int NN = 31;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [SW-1:0] in_data = '0;
  logic          in_ready, node_wen, busy, done, err;
  logic [AW-1:0] node_addr;
  logic [SW-1:0] node_wdata;

  kd_tree_config_ctrl #(.STORAGE_WIDTH(SW), .NUM_NODES(NN), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .node_wen(node_wen), .node_addr(node_addr), .node_wdata(node_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: phase 0 idle, 1 loading, 2 done
  int            ph;
  logic          m_err, m_wen;
  int            last_addr;
  logic [SW-1:0] last_data;
  logic [SW-1:0] acc_q[$];
  int            nwr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; m_err = 1'b0; m_wen = 1'b0;
    last_addr = 0; last_data = '0;
    acc_q.delete(); nwr = 0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wen", node_wen, 0);
    chk("rst_addr", node_addr, 0);
    chk("rst_wdata", node_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
  endtask

  // One clock: drive, advance the model on the edge, then check outputs.
  task automatic cycle(input logic s, input logic v, input logic [SW-1:0] d);
    start = s; in_valid = v; in_data = d;
    @(posedge clk);
    m_wen = 1'b0;
    if (ph == 1) begin
      if (v) begin
        m_wen = 1'b1;
        last_addr = acc_q.size();
        last_data = d;
        acc_q.push_back(d);
`ifdef KD_CFG_IDX_CHECK_EN
        if (d[2:0] > 3'd4) m_err = 1'b1;
`endif
        if (acc_q.size() == NN) ph = 2;
      end
    end else if (s) begin
      ph = 1; m_err = 1'b0; acc_q.delete(); nwr = 0;
    end
    #1;
    chk("in_ready", in_ready, ph == 1);
    chk("busy", busy, ph == 1);
    chk("done", done, ph == 2);
    chk("wen", node_wen, m_wen);
    chk("err", err, m_err);
    chk("addr", node_addr, last_addr);
    chk("wdata", node_wdata, last_data);
    if (node_wen) nwr++;
    @(negedge clk);
  endtask

  // mode 0: data=index, valid high; 1: valid toggles; 2: random valid + mid-load start; 3: random, word 5 = 7
  task automatic run_pass(input int mode);
    int            guard = 0;
    int            k = 0;
    logic          v, s;
    logic [SW-1:0] d;
    cycle(1'b1, 1'b0, '0);
    while (ph == 1 && guard < 600) begin
      int idx = acc_q.size();
      s = 1'b0;
      case (mode)
        0:       begin v = 1'b1;          d = SW'(idx); end
        1:       begin v = (k % 2 == 0);  d = SW'($urandom); end
        2:       begin v = 1'($urandom);  d = SW'($urandom); s = (idx == 10); end
        default: begin v = 1'($urandom);  d = (idx == 5) ? SW'(7) : SW'($urandom); end
      endcase
      cycle(s, v, d);
      k++; guard++;
    end
    chk("pass_timeout", guard < 600, 1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, SW'($urandom));
    chk("pass_writes", nwr, NN);
    chk("pass_accepts", acc_q.size(), NN);
  endtask

  initial begin
    model_reset();
    #12;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 1'b1, SW'(3));
    cycle(1'b0, 1'b0, '0);

    run_pass(0);
    run_pass(1);
    run_pass(2);
    run_pass(3);
    run_pass(3);

    // abort a pass after 12 accepted words with an asynchronous reset
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, SW'($urandom));
    chk("abort_writes", nwr, 12);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_reset_vals();
    @(posedge clk);
    #1 chk("abort_no_wen", node_wen, 0);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 1'b1, SW'(1));
    run_pass(2);
    run_pass(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule
